// File: rtl/line_buffer_7x7_pkg.sv
// line_buffer_7x7_pkg: shared pixel/window constants and counter sizing for the 7x7 line buffer.
package line_buffer_7x7_pkg;
    localparam int PIXEL_W = 8;
    localparam int WIN     = 7;
    localparam int LINES   = WIN - 1;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/line_buffer_7x7_line_delay.sv
// line_delay: one image row of delay; output is the pixel written exactly COLS accepted pixels earlier.
module line_delay
    import line_buffer_7x7_pkg::*;
#(
    parameter int COLS = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PIXEL_W-1:0] din,
    output logic [PIXEL_W-1:0] dout
);
    localparam int PW = cnt_w(COLS);

    logic [PIXEL_W-1:0] mem [COLS];
    logic [PW-1:0]      ptr;

    // Read is combinational so the chained stages all see the same pointer slot in one cycle.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (en)
            ptr <= (ptr == PW'(COLS - 1)) ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (en && !rst)
            mem[ptr] <= din;
    end
endmodule

// File: rtl/line_buffer_7x7.sv
// line_buffer_7x7: streams raster pixels through six row delays and emits a registered 7-pixel vertical column.
module line_buffer_7x7
    import line_buffer_7x7_pkg::*;
#(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done_i,
    input  logic [PIXEL_W-1:0] data_i,
    output logic [PIXEL_W-1:0] S1_o,
    output logic [PIXEL_W-1:0] S2_o,
    output logic [PIXEL_W-1:0] S3_o,
    output logic [PIXEL_W-1:0] S4_o,
    output logic [PIXEL_W-1:0] S5_o,
    output logic [PIXEL_W-1:0] S6_o,
    output logic [PIXEL_W-1:0] S7_o,
    output logic               done_o,
    output logic               progress_done_o
);
    localparam int CW = cnt_w(COLS);
    localparam int RW = cnt_w(ROWS);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               col_last;
    logic               row_last;
    logic [PIXEL_W-1:0] tap [LINES+1];
    logic [PIXEL_W-1:0] s   [WIN];

    assign col_last = col == CW'(COLS - 1);
    assign row_last = row == RW'(ROWS - 1);
    assign tap[0]   = data_i;

    // tap[k] carries the pixel k rows above the incoming one.
    genvar g;
    for (g = 0; g < LINES; g++) begin : g_stage
        line_delay #(.COLS(COLS)) u_delay (
            .clk (clk),
            .rst (rst),
            .en  (done_i),
            .din (tap[g]),
            .dout(tap[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col             <= '0;
            row             <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
            for (int k = 0; k < WIN; k++) s[k] <= '0;
        end else begin
            done_o          <= done_i && (row >= RW'(LINES));
            progress_done_o <= done_i && col_last && row_last;
            if (done_i) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
                for (int k = 0; k < WIN; k++) s[WIN-1-k] <= tap[k];
            end
        end
    end

    assign S1_o = s[0];
    assign S2_o = s[1];
    assign S3_o = s[2];
    assign S4_o = s[3];
    assign S5_o = s[4];
    assign S6_o = s[5];
    assign S7_o = s[6];
endmodule
